// File: rtl/door_pkg.sv
// Shared definitions for the door plant model and the door controller.
// Pin indices fix the loopback wiring between the two in one place.
package door_pkg;

   typedef enum logic [2:0] {
      ST_CLOSED  = 3'd0,
      ST_OPENING = 3'd1,
      ST_OPEN    = 3'd2,
      ST_CLOSING = 3'd3,
      ST_STALL   = 3'd4,
      ST_FAULT   = 3'd5
   } plant_state_t;

   localparam int POS_W   = 5;

   localparam int MOTOR_W = 2;
   localparam int PIN_MA  = 0;
   localparam int PIN_MC  = 1;

   localparam int LIMIT_W = 2;
   localparam int PIN_LA  = 0;
   localparam int PIN_LC  = 1;

   function automatic int presc_width(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/door_step_prescaler.sv
// Divides enabled run cycles down to one step pulse every STEP_DIV cycles.
// The pulse is combinational so the owner can act on it at the same edge.
module door_step_prescaler
   import door_pkg::*;
#(
   parameter int STEP_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   input  logic run,
   input  logic clr,
   output logic step
);

   localparam int            PW = presc_width(STEP_DIV);
   localparam logic [PW-1:0] TC = PW'(STEP_DIV - 1);

   logic [PW-1:0] r_cnt;
   logic          w_tc;

   assign w_tc = (r_cnt == TC);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (ena) begin
         if (clr) begin
            r_cnt <= '0;
         end else if (run) begin
            r_cnt <= w_tc ? '0 : r_cnt + PW'(1);
         end
      end
   end

   assign step = run & ~clr & w_tc;

endmodule

// File: rtl/door_plant_model.sv
// Behavioural motorised-door plant: turns motor commands into limit switches
// via a saturating position counter, for on-chip loopback against the door FSM.
module door_plant_model
   import door_pkg::*;
#(
   parameter int TRAVEL_STEPS = 16,
   parameter int STEP_DIV     = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             ma,
   input  logic             mc,
   input  logic             obstruct,
   output logic             la,
   output logic             lc,
   output logic [POS_W-1:0] pos,
   output logic             moving,
   output logic             stalled,
   output logic             fault
);

   localparam logic [POS_W-1:0] POS_MAX = POS_W'(TRAVEL_STEPS);

   plant_state_t       r_state, w_state_next;
   logic [POS_W-1:0]   r_pos, w_pos_next;
   logic [MOTOR_W-1:0] w_motor;
   logic [LIMIT_W-1:0] w_limit;
   logic               w_at_max, w_at_min;
   logic               w_fault_cmd, w_open_cmd, w_close_cmd;
   logic               w_run, w_step;
   logic [POS_W-1:0]   w_pos_inc, w_pos_dec;

   always_comb begin
      w_motor         = '0;
      w_motor[PIN_MA] = ma;
      w_motor[PIN_MC] = mc;
   end

   assign w_fault_cmd = w_motor[PIN_MA] & w_motor[PIN_MC];
   assign w_open_cmd  = w_motor[PIN_MA] & ~w_motor[PIN_MC];
   assign w_close_cmd = w_motor[PIN_MC] & ~w_motor[PIN_MA];

   assign w_at_max  = (r_pos == POS_MAX);
   assign w_at_min  = (r_pos == '0);
   assign w_pos_inc = r_pos + POS_W'(1);
   assign w_pos_dec = r_pos - POS_W'(1);

   // Step progress only survives while the door keeps moving the same way.
   assign w_run = ((r_state == ST_OPENING) && w_open_cmd) ||
                  ((r_state == ST_CLOSING) && w_close_cmd && !obstruct);

   door_step_prescaler #(
      .STEP_DIV (STEP_DIV)
   ) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .run   (w_run),
      .clr   (~w_run),
      .step  (w_step)
   );

   function automatic plant_state_t rest_state(input logic at_min, input logic at_max);
      if (at_min)      return ST_CLOSED;
      else if (at_max) return ST_OPEN;
      else             return ST_STALL;
   endfunction

   always_comb begin
      w_state_next = r_state;
      w_pos_next   = r_pos;
      if (w_fault_cmd) begin
         w_state_next = ST_FAULT;
      end else if (r_state == ST_FAULT) begin
         if (!w_open_cmd && !w_close_cmd) begin
            w_state_next = rest_state(w_at_min, w_at_max);
         end
      end else if (w_open_cmd) begin
         if (w_at_max) begin
            w_state_next = ST_OPEN;
         end else begin
            w_state_next = ST_OPENING;
            if (w_step) begin
               w_pos_next = w_pos_inc;
               if (w_pos_inc == POS_MAX) begin
                  w_state_next = ST_OPEN;
               end
            end
         end
      end else if (w_close_cmd) begin
         if (obstruct) begin
            w_state_next = ST_STALL;
         end else if (w_at_min) begin
            w_state_next = ST_CLOSED;
         end else begin
            w_state_next = ST_CLOSING;
            if (w_step) begin
               w_pos_next = w_pos_dec;
               if (w_pos_dec == '0) begin
                  w_state_next = ST_CLOSED;
               end
            end
         end
      end else begin
         w_state_next = rest_state(w_at_min, w_at_max);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_CLOSED;
         r_pos   <= '0;
      end else if (ena) begin
         r_state <= w_state_next;
         r_pos   <= w_pos_next;
      end
   end

   assign w_limit[PIN_LA] = w_at_max;
   assign w_limit[PIN_LC] = w_at_min;

   assign la      = w_limit[PIN_LA];
   assign lc      = w_limit[PIN_LC];
   assign pos     = r_pos;
   assign moving  = (r_state == ST_OPENING) || (r_state == ST_CLOSING);
   assign stalled = (r_state == ST_STALL);
   assign fault   = (r_state == ST_FAULT);

endmodule

// File: tb/tb_door_plant_model.sv
// Directed bench for door_plant_model: stimulus queues expected snapshots
// tagged with a cycle number; a monitor compares them at that cycle's negedge.
module tb_door_plant_model;

   logic       clk = 1'b0;
   logic       rst_n, ena, ma, mc, obstruct;
   logic       la, lc, moving, stalled, fault;
   logic [4:0] pos;

   typedef struct {
      int         cyc;
      string      nm;
      logic [9:0] exp;
   } ent_t;

   ent_t sb_q[$];
   int   cyc     = 0;
   int   n_tests = 0;
   int   n_fail  = 0;

   door_plant_model #(
      .TRAVEL_STEPS (16),
      .STEP_DIV     (4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .ma       (ma),
      .mc       (mc),
      .obstruct (obstruct),
      .la       (la),
      .lc       (lc),
      .pos      (pos),
      .moving   (moving),
      .stalled  (stalled),
      .fault    (fault)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Expected snapshot dly posedges from now: {pos, la, lc, moving, stalled, fault}.
   task automatic expect_st(input int dly, input string nm, input int p,
                            input logic mv, input logic st, input logic ft);
      ent_t       e;
      logic [4:0] pv;
      pv    = 5'(p);
      e.cyc = cyc + dly;
      e.nm  = nm;
      e.exp = {pv, (p == 16), (p == 0), mv, st, ft};
      sb_q.push_back(e);
   endtask

   task automatic nclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin : monitor
      ent_t       e;
      logic [9:0] got;
      forever begin
         @(negedge clk);
         while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e   = sb_q.pop_front();
            got = {pos, la, lc, moving, stalled, fault};
            n_tests++;
            if (e.cyc != cyc || got !== e.exp) begin
               n_fail++;
               $display("FAIL %s cyc=%0d due=%0d got pos=%0d la/lc/mv/st/ft=%b exp pos=%0d la/lc/mv/st/ft=%b",
                        e.nm, cyc, e.cyc, got[9:5], got[4:0], e.exp[9:5], e.exp[4:0]);
            end else begin
               $display("[TB] ok %s cyc=%0d pos=%0d la/lc/mv/st/ft=%b",
                        e.nm, cyc, got[9:5], got[4:0]);
            end
         end
      end
   end

   initial begin : stimulus
      rst_n = 1'b0; ena = 1'b1; ma = 1'b0; mc = 1'b0; obstruct = 1'b0;

      // Reset held, then released
      @(negedge clk);
      expect_st(1, "rst_hold", 0, 0, 0, 0);
      nclk(2);
      rst_n = 1'b1;
      expect_st(2, "rst_release", 0, 0, 0, 0);
      nclk(2);

      // Full open: pos=k at 1+4k, limit at 65, then held
      ma = 1'b1;
      expect_st(4,  "open_first_wait", 0,  1, 0, 0);
      expect_st(5,  "open_first_step", 1,  1, 0, 0);
      expect_st(64, "open_pre_limit",  15, 1, 0, 0);
      expect_st(65, "open_limit",      16, 0, 0, 0);
      expect_st(80, "open_hold",       16, 0, 0, 0);
      nclk(80);

      // Close from OPEN: la drops at first step, closed at 65
      ma = 1'b0; mc = 1'b1;
      expect_st(4,  "close_first_wait", 16, 1, 0, 0);
      expect_st(5,  "close_first_step", 15, 1, 0, 0);
      expect_st(65, "close_limit",      0,  0, 0, 0);
      nclk(65);

      // Reopen, then close into an obstruction at pos=10 with the prescaler at terminal count
      ma = 1'b1; mc = 1'b0;
      expect_st(65, "reopen_limit", 16, 0, 0, 0);
      nclk(65);
      ma = 1'b0; mc = 1'b1;
      expect_st(28, "obs_pre", 10, 1, 0, 0);
      nclk(28);
      obstruct = 1'b1;
      expect_st(1,  "obs_stall",      10, 0, 1, 0);
      expect_st(20, "obs_stall_hold", 10, 0, 1, 0);
      nclk(20);
      obstruct = 1'b0;
      expect_st(1,  "obs_resume",      10, 1, 0, 0);
      expect_st(5,  "obs_fresh_step",  9,  1, 0, 0);
      expect_st(40, "obs_pre_closed",  1,  1, 0, 0);
      expect_st(41, "obs_closed",      0,  0, 0, 0);
      nclk(41);

      // Fault at pos=7, one-sided release stays faulted, full release stalls, then reopen
      ma = 1'b1; mc = 1'b0;
      expect_st(29, "flt_pre", 7, 1, 0, 0);
      nclk(29);
      mc = 1'b1;
      expect_st(1, "flt_enter", 7, 0, 0, 1);
      expect_st(5, "flt_hold",  7, 0, 0, 1);
      nclk(5);
      mc = 1'b0;
      expect_st(1, "flt_one_released", 7, 0, 0, 1);
      expect_st(3, "flt_one_hold",     7, 0, 0, 1);
      nclk(3);
      ma = 1'b0;
      expect_st(1, "flt_to_stall", 7, 0, 1, 0);
      expect_st(3, "stall_hold",   7, 0, 1, 0);
      nclk(3);
      ma = 1'b1;
      expect_st(1,  "stall_reopen",  7,  1, 0, 0);
      expect_st(5,  "stall_step",    8,  1, 0, 0);
      expect_st(37, "stall_to_open", 16, 0, 0, 0);
      nclk(37);

      // Clock enable: close, then open with a 10-cycle ena gap
      ma = 1'b0; mc = 1'b1;
      expect_st(65, "ena_closed", 0, 0, 0, 0);
      nclk(65);
      ma = 1'b1; mc = 1'b0;
      expect_st(10, "ena_pre", 2, 1, 0, 0);
      nclk(10);
      ena = 1'b0;
      expect_st(1,  "ena_frozen",     2, 1, 0, 0);
      expect_st(10, "ena_frozen_end", 2, 1, 0, 0);
      nclk(10);
      ena = 1'b1;
      expect_st(2,  "ena_resume_wait", 2,  1, 0, 0);
      expect_st(3,  "ena_resume_step", 3,  1, 0, 0);
      expect_st(54, "ena_pre_limit",   15, 1, 0, 0);
      expect_st(55, "ena_open",        16, 0, 0, 0);
      nclk(55);

      // Asynchronous reset mid-travel at pos=9
      ma = 1'b0; mc = 1'b1;
      expect_st(29, "rst_pre", 9, 1, 0, 0);
      nclk(29);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      expect_st(0, "rst_async", 0, 0, 0, 0);
      nclk(2);
      rst_n = 1'b1; mc = 1'b0;
      expect_st(2, "rst_after", 0, 0, 0, 0);
      nclk(3);

      for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
      if (sb_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard_drain pending=%0d required=0", sb_q.size());
      end
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/door_plant_model.md
Name: door_plant_model

Overview:
- Behavioural plant model of the motorised door: the far end of the door-controller interface.
- Consumes the controller's motor commands (open motor, close motor) and produces the limit-switch signals (open limit, closed limit) from an internal position counter.
- Used on-chip as a loopback target so the door FSM can be exercised without external hardware. Also exposes position, motion and fault status for debug pins.

Parameters:
- TRAVEL_STEPS, 16: number of position steps between fully closed (0) and fully open (TRAVEL_STEPS); range 2..31.
- STEP_DIV, 4: enabled clock cycles per position step; range 1..16.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  clock enable; all state holds when low
- ma  in  1  open-motor command from the controller
- mc  in  1  close-motor command from the controller
- obstruct  in  1  obstruction present in the doorway; blocks closing motion only
- la  out  1  open limit switch, high when pos == TRAVEL_STEPS
- lc  out  1  closed limit switch, high when pos == 0
- pos  out  5  current door position
- moving  out  1  high in OPENING or CLOSING
- stalled  out  1  high in STALL
- fault  out  1  high in FAULT

Behaviour:
- Reset is asynchronous and active-low: state=CLOSED, pos=0, prescaler=0, lc=1, la=0, moving=0, stalled=0, fault=0.
- All registers update only on rising clk with ena=1.
- Outputs are decoded from registered state/pos; no added latency.
- States (encoding in package): CLOSED, OPENING, OPEN, CLOSING, STALL, FAULT.
- Transition priority, evaluated each enabled cycle:
  1. ma=1 and mc=1 in any state -> FAULT. pos holds and prescaler clears.
  2. FAULT: stays until ma=0 and mc=0 in the same cycle, then goes to CLOSED if pos==0, OPEN if pos==TRAVEL_STEPS, else STALL.
  3. ma=1 (mc=0) -> OPENING, unless pos==TRAVEL_STEPS, in which case -> OPEN.
  4. mc=1 (ma=0), obstruct=0 -> CLOSING, unless pos==0, in which case -> CLOSED.
  5. mc=1, obstruct=1 -> STALL. pos holds and prescaler clears.
  6. ma=0, mc=0 -> CLOSED if pos==0, OPEN if pos==TRAVEL_STEPS, else STALL. A released motor stops the door mid-travel.
- Motion:
  - In OPENING or CLOSING, the prescaler increments each enabled cycle.
  - When the prescaler reaches STEP_DIV-1, it clears and pos steps by +1 (OPENING) or -1 (CLOSING).
- Full travel takes TRAVEL_STEPS*STEP_DIV enabled cycles after the first cycle the command is sampled.
- Saturation: pos never exceeds TRAVEL_STEPS and never goes below 0.
  - The step that reaches a limit also moves the state to OPEN or CLOSED in the same edge.
  - The prescaler clears at that point.
- Direction reversal (OPENING<->CLOSING) clears the prescaler. Partial step progress is discarded.
- obstruct while OPENING has no effect.
- obstruct rising while CLOSING -> STALL on the next edge. pos does not change on that edge even if the prescaler was at terminal count.
- Prescaler width: ceil(log2(STEP_DIV)), minimum 1 bit. pos width is fixed at 5 bits.
- ena low mid-motion freezes pos and the prescaler. Motion resumes exactly where it left off.
- Reset asserted mid-travel returns pos to 0 immediately. This is a model convenience, not physical behaviour.

Decomposition:
- Shared package door_pkg holds:
  - the plant state enum/localparams
  - the pin index constants for the open/close motor and the open/closed limit, shared with the door controller so loopback wiring is defined once
- One sub-module, door_step_prescaler.
  - Inputs: clk, rst_n, ena, run, clr.
  - Output: step pulse every STEP_DIV enabled run cycles.
- The FSM, position counter and saturation logic stay in door_plant_model.

Test Plan (defaults TRAVEL_STEPS=16, STEP_DIV=4):
- Reset check: hold rst_n=0, then release -> pos=0, lc=1, la=0, fault=0, state CLOSED.
- Full open: ma=1 held from cycle 0 -> pos increments every 4 enabled cycles. la=1 and pos=16 exactly 64 cycles after ma is sampled. moving drops on the same edge. Holding ma longer keeps pos=16.
- Open then close: from OPEN, mc=1 -> lc=1 and pos=0 after 64 cycles. la drops after the first step (cycle 4).
- Obstruction: close from pos=16; at pos=10 assert obstruct=1 for 20 cycles -> stalled=1, pos holds 10. Release obstruct -> closing resumes with a fresh 4-cycle step, reaching pos=0 after 40 more cycles.
- Fault: ma=1 and mc=1 at pos=7 -> fault=1, pos stays 7. Drop both -> STALL, fault=0. ma=1 -> opening resumes to pos=16.
- Enable and reset: toggle ena low for 10 cycles mid-opening -> pos and prescaler frozen, total open time is 64 enabled cycles. Assert rst_n=0 at pos=9 -> pos=0 and lc=1 asynchronously.
